// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: fixed-latency multiply, 32-step restoring
// divide, and direct MTHI/MTLO writes. busy stalls execute while an op is in flight.
module hilo_muldiv_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [4:0] MUL_CNT  = 5'(MUL_LAT - 1);

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [63:0] prod_reg, prod_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic        done_reg, done_next;
  logic [31:0] divisor_reg, divisor_next;
  logic [31:0] quot_reg, quot_next;
  logic [31:0] rem_reg, rem_next;
  logic        qs_reg, qs_next;
  logic        rs_reg, rs_next;

  // Sign-extending only for MULT makes the low 64 bits of one multiplier
  // correct for both signed and unsigned forms.
  logic        mul_signed;
  logic [63:0] mul_a, mul_b, mul_prod;
  logic        div_signed;
  logic [31:0] a_abs, b_abs;
  logic [32:0] shifted;
  logic        fits;

  always_comb begin
    mul_signed = (op == OP_MULT);
    mul_a      = {{32{a[31] & mul_signed}}, a};
    mul_b      = {{32{b[31] & mul_signed}}, b};
    mul_prod   = mul_a * mul_b;
    div_signed = (op == OP_DIV);
    a_abs      = (div_signed && a[31]) ? (32'd0 - a) : a;
    b_abs      = (div_signed && b[31]) ? (32'd0 - b) : b;
    shifted    = {rem_reg, quot_reg[31]};
    fits       = (shifted >= {1'b0, divisor_reg});
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    prod_next    = prod_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    done_next    = 1'b0;
    divisor_next = divisor_reg;
    quot_next    = quot_reg;
    rem_next     = rem_reg;
    qs_next      = qs_reg;
    rs_next      = rs_reg;

    case (state_reg)
      IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              prod_next  = mul_prod;
              cnt_next   = MUL_CNT;
              state_next = MUL;
            end
            OP_DIV, OP_DIVU: begin
              divisor_next = b_abs;
              quot_next    = a_abs;
              rem_next     = 32'd0;
              qs_next      = div_signed & (a[31] ^ b[31]);
              rs_next      = div_signed & a[31];
              cnt_next     = 5'd31;
              state_next   = DIV;
            end
            OP_MTHI: hi_next = a;
            OP_MTLO: lo_next = a;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (flush) begin
          state_next = IDLE;
        end else if (cnt_reg == 5'd0) begin
          {hi_next, lo_next} = prod_reg;
          done_next          = 1'b1;
          state_next         = IDLE;
        end else begin
          cnt_next = cnt_reg - 5'd1;
        end
      end
      DIV: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          // Remainder stays below the divisor, so the low 32 bits always hold it.
          rem_next  = fits ? 32'(shifted - {1'b0, divisor_reg}) : shifted[31:0];
          quot_next = {quot_reg[30:0], fits};
          if (cnt_reg == 5'd0) begin
            state_next = FIX;
          end else begin
            cnt_next = cnt_reg - 5'd1;
          end
        end
      end
      FIX: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          if (divisor_reg != 32'd0) begin
            lo_next = qs_reg ? (32'd0 - quot_reg) : quot_reg;
            hi_next = rs_reg ? (32'd0 - rem_reg) : rem_reg;
          end
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 5'd0;
      prod_reg    <= 64'd0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      done_reg    <= 1'b0;
      divisor_reg <= 32'd0;
      quot_reg    <= 32'd0;
      rem_reg     <= 32'd0;
      qs_reg      <= 1'b0;
      rs_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      prod_reg    <= prod_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      done_reg    <= done_next;
      divisor_reg <= divisor_next;
      quot_reg    <= quot_next;
      rem_reg     <= rem_next;
      qs_reg      <= qs_next;
      rs_reg      <= rs_next;
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
